// File: rtl/mem_store_ctrl_pkg.sv
// Shared definitions for the store path: default widths, the byte width of the
// RAM port, the st_size encodings and a helper that turns a size code into a
// byte count.
package mem_defs;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  // Number of bytes written for a size code; 0 for the reserved code.
  function automatic int unsigned size_nbytes(input logic [1:0] sz);
    int unsigned n;
    case (sz)
      SZ_BYTE: n = 1;
      SZ_HALF: n = 2;
      SZ_WORD: n = 4;
      default: n = 0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_store_ctrl_byte_sel.sv
// store_byte_sel: combinational byte-lane mux for the store path.
// Ports:
//   data      in   DATA_W  latched store data, lane 0 = data[7:0]
//   idx       in   IDX_W   lane index
//   lane_byte out  8       selected byte (0 for an out-of-range index)
module store_byte_sel
  import mem_defs::BYTE_W;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  idx,
  output logic [BYTE_W-1:0] lane_byte
);

  localparam int unsigned NBYTES = DATA_W / BYTE_W;

  always_comb begin
    lane_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) lane_byte = data[BYTE_W*i +: BYTE_W];
    end
  end

endmodule

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: serialises one store (address, data, size) from the MEM stage
// onto a byte-wide RAM port, one byte per clock, little-endian.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   st_req       store request, level, held until accepted
//   st_addr      byte address of the least-significant byte
//   st_data      store data, byte 0 = st_data[7:0]
//   st_size      00 byte, 01 half, 10 word, 11 reserved
//   st_busy      store in progress, requests ignored
//   st_done      one-cycle pulse at the end of a store (or a rejected one)
//   st_err       one-cycle pulse with st_done for the reserved size
//   ram_ce/we    RAM chip/write enable (identical here)
//   ram_addr     RAM byte address
//   ram_dout     RAM write data
// All outputs are registered.
module mem_store_ctrl
  import mem_defs::BYTE_W, mem_defs::SZ_RSVD, mem_defs::size_nbytes;
#(
  parameter int unsigned ADDR_W = mem_defs::ADDR_W,
  parameter int unsigned DATA_W = mem_defs::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout
);

  localparam int unsigned NBYTES = DATA_W / BYTE_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES) + 1;
  localparam int unsigned LANE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  nbytes_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  req_nbytes;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        lane_byte;

  assign req_nbytes = CNT_W'(size_nbytes(st_size));
  // ADDR_W-wide add: the carry out is dropped so the address wraps.
  assign next_addr  = base_addr + ADDR_W'(idx_q);

  store_byte_sel #(
    .DATA_W (DATA_W),
    .IDX_W  (LANE_W)
  ) u_byte_sel (
    .data      (data_q),
    .idx       (idx_q[LANE_W-1:0]),
    .lane_byte (lane_byte)
  );

  // Byte 0 is driven straight from the request on the accept edge, so idx_q
  // holds the index of the byte to drive on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_addr <= '0;
      data_q    <= '0;
      nbytes_q  <= '0;
      idx_q     <= '0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= '0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      if (state == S_IDLE) begin
        if (st_req) begin
          if (st_size == SZ_RSVD) begin
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            base_addr <= st_addr;
            data_q    <= st_data;
            nbytes_q  <= req_nbytes;
            idx_q     <= CNT_W'(1);
            ram_ce    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= st_addr;
            ram_dout  <= st_data[BYTE_W-1:0];
            st_busy   <= 1'b1;
            state     <= S_WRITE;
          end
        end
      end else begin
        if (idx_q == nbytes_q) begin
          ram_ce   <= 1'b0;
          ram_we   <= 1'b0;
          ram_addr <= '0;
          ram_dout <= '0;
          st_busy  <= 1'b0;
          st_done  <= 1'b1;
          state    <= S_IDLE;
        end else begin
          ram_addr <= next_addr;
          ram_dout <= lane_byte;
          idx_q    <= idx_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_store_ctrl.sv
module tb_mem_store_ctrl;

  logic        clk;
  logic        rst_n;
  logic        st_req;
  logic [15:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_busy, st_done, st_err, ram_ce, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;

  mem_store_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_size  (st_size),
    .st_busy  (st_busy),
    .st_done  (st_done),
    .st_err   (st_err),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted store expands into the list of
  // per-cycle output values it must produce; the list plays out one
  // entry per clock and a new store is taken only once it is empty.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        ce;
    logic [15:0] addr;
    logic [7:0]  dout;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        cur = '0;
      end else begin
        if (exp_q.size() == 0 && st_req) begin
          if (st_size == 2'b11) begin
            exp_q.push_back('{busy: 1'b0, done: 1'b1, err: 1'b1, ce: 1'b0,
                              addr: 16'h0, dout: 8'h0});
          end else begin
            int n;
            logic [31:0] d;
            n = 1 << st_size;
            d = st_data;
            for (int i = 0; i < n; i++) begin
              exp_t e;
              e = '0;
              e.busy = 1'b1;
              e.ce   = 1'b1;
              e.addr = 16'(st_addr + i);
              e.dout = 8'(d >> (8 * i));
              exp_q.push_back(e);
            end
            exp_q.push_back('{busy: 1'b0, done: 1'b1, err: 1'b0, ce: 1'b0,
                              addr: 16'h0, dout: 8'h0});
          end
        end
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
      end
    end
  end

  // Bench-side RAM fed by the DUT port, plus the compare process.
  logic [7:0] ram [0:65535];
  int nwrites = 0;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (ram_ce && ram_we) begin
        ram[ram_addr] = ram_dout;
        nwrites++;
      end
      check("m_busy", st_busy, cur.busy);
      check("m_done", st_done, cur.done);
      check("m_err", st_err, cur.err);
      check("m_ce", ram_ce, cur.ce);
      check("m_we", ram_we, cur.ce);
      check("m_addr", ram_addr, cur.addr);
      check("m_dout", ram_dout, cur.dout);
      check("busy_done_excl", st_busy & st_done, 0);
    end
  end

  // Directed store with hand-computed per-byte addresses/data (lane i at
  // bits [16i+:16] / [8i+:8]); inputs are scrambled right after acceptance.
  task automatic store_chk(input string nm, input logic [15:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int n, input logic [63:0] ea,
                           input logic [31:0] ed, input logic eerr);
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = a; st_data = d; st_size = sz;
    @(posedge clk); #1;
    st_req = 1'b0; st_addr = ~a; st_data = ~d;
    st_size = (sz == 2'b10) ? 2'b00 : 2'b10;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({nm, "_ce"}, ram_ce & ram_we, 1);
      check({nm, "_busy"}, st_busy, 1);
      check({nm, "_addr"}, ram_addr, ea[16*i +: 16]);
      check({nm, "_dout"}, ram_dout, ed[8*i +: 8]);
    end
    @(negedge clk);
    check({nm, "_done"}, st_done, 1);
    check({nm, "_err"}, st_err, eerr);
    check({nm, "_idle"}, {st_busy, ram_ce, ram_we, ram_addr, ram_dout}, 0);
  endtask

  int w0;

  initial begin
    rst_n = 1'b0; st_req = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    #12;
    check("reset_outs", {st_busy, st_done, st_err, ram_ce, ram_we, ram_addr, ram_dout}, 0);
    #10 rst_n = 1'b1;

    // 1: word
    store_chk("word", 16'h0010, 32'hA1B2C3D4, 2'b10, 4, 64'h0013_0012_0011_0010, 32'hA1B2C3D4, 1'b0);
    // 2: byte
    store_chk("byte", 16'h0042, 32'h000000EE, 2'b00, 1, 64'h0000_0000_0000_0042, 32'h000000EE, 1'b0);
    // 3: half wrapping past the top of the address space
    store_chk("wrap", 16'hFFFF, 32'h00005A3C, 2'b01, 2, 64'h0000_0000_0000_FFFF, 32'h00005A3C, 1'b0);
    check("wrap_ram0", ram[16'hFFFF], 8'h3C);
    check("wrap_ram1", ram[16'h0000], 8'h5A);

    // 4: back-to-back with req held high
    w0 = nwrites;
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = 16'h0100; st_data = 32'hDEADBEEF; st_size = 2'b10;
    @(posedge clk); #1;
    st_addr = 16'h0180; st_data = 32'h00000077; st_size = 2'b00;
    repeat (4) @(negedge clk);
    check("b2b_last_addr", ram_addr, 16'h0103);
    check("b2b_last_dout", ram_dout, 8'hDE);
    @(negedge clk);
    check("b2b_done1", {st_done, st_busy}, 2'b10);
    @(posedge clk); #1;
    st_req = 1'b0;
    @(negedge clk);
    check("b2b_2nd_addr", ram_addr, 16'h0180);
    check("b2b_2nd_dout", ram_dout, 8'h77);
    @(negedge clk);
    check("b2b_done2", st_done, 1);
    check("b2b_writes", nwrites - w0, 5);
    check("b2b_ram", {ram[16'h0103], ram[16'h0102], ram[16'h0101], ram[16'h0100]}, 32'hDEADBEEF);

    // 5a: request while busy is dropped
    w0 = nwrites;
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = 16'h0200; st_data = 32'h0BADF00D; st_size = 2'b10;
    @(posedge clk); #1;
    st_req = 1'b0;
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = 16'h0280; st_data = 32'hFFFFFFFF; st_size = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    st_req = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_ign_writes", nwrites - w0, 4);
    check("busy_ign_ram", {ram[16'h0203], ram[16'h0202], ram[16'h0201], ram[16'h0200]}, 32'h0BADF00D);
    check("busy_ign_280", ram[16'h0280], 8'h00);

    // 5b: reserved size
    w0 = nwrites;
    store_chk("rsvd", 16'h0300, 32'h12345678, 2'b11, 0, 64'h0, 32'h0, 1'b1);
    check("rsvd_writes", nwrites - w0, 0);

    // 6: reset during byte 2 of a word
    @(posedge clk); #1;
    st_req = 1'b1; st_addr = 16'h0500; st_data = 32'h11223344; st_size = 2'b10;
    @(posedge clk); #1;
    st_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_b2_addr", ram_addr, 16'h0502);
    check("rst_b2_dout", ram_dout, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {st_busy, st_done, st_err, ram_ce, ram_we, ram_addr, ram_dout}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("rst_ram_kept", {ram[16'h0502], ram[16'h0501], ram[16'h0500]}, 24'h223344);
    check("rst_ram_3", ram[16'h0503], 8'h00);
    store_chk("post_rst", 16'h0400, 32'h0000BEEF, 2'b01, 2, 64'h0000_0000_0401_0400, 32'h0000BEEF, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
